// File: rtl/mul_pkg.sv
// Shared definitions for the iterative Booth multiplier and the Wallace path.
//   state_e    : multiplier control states
//   SEL_*      : bit positions of the one-hot Booth selector
//   booth_sel  : radix-4 Booth window -> one-hot selector
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // One-hot selector ordering, shared with the Wallace selector.
  localparam int SEL_NEG  = 0;
  localparam int SEL_POS  = 1;
  localparam int SEL_DNEG = 2;
  localparam int SEL_DPOS = 3;

  // Window bits: w[2] = y_add, w[1] = y, w[0] = y_sub.
  function automatic logic [3:0] booth_sel(input logic [2:0] w);
    logic [3:0] sel;
    sel = '0;
    case (w)
      3'b001, 3'b010: sel[SEL_POS]  = 1'b1;
      3'b011:         sel[SEL_DPOS] = 1'b1;
      3'b100:         sel[SEL_DNEG] = 1'b1;
      3'b101, 3'b110: sel[SEL_NEG]  = 1'b1;
      default:        sel = '0;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator (combinational).
//   i_window : 3-bit Booth window {y_add, y, y_sub}
//   i_xs     : sign-extended multiplicand, already aligned to the digit weight
//   o_addend : 0, +-Xs or +-2Xs, modulo 2^(2*XLEN+4)
module booth_pp_gen
  import mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]          i_window,
  input  logic [2*XLEN+3:0]   i_xs,
  output logic [2*XLEN+3:0]   o_addend
);

  localparam int AW = 2*XLEN+4;

  logic [3:0]    w_sel;
  logic [AW-1:0] w_dbl;

  assign w_sel = booth_sel(i_window);
  assign w_dbl = {i_xs[AW-2:0], 1'b0};

  always_comb begin
    o_addend = '0;
    if (w_sel[SEL_POS])       o_addend = i_xs;
    else if (w_sel[SEL_NEG])  o_addend = -i_xs;
    else if (w_sel[SEL_DPOS]) o_addend = w_dbl;
    else if (w_sel[SEL_DNEG]) o_addend = -w_dbl;
  end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier, one Booth digit per cycle.
//   clock, reset         : rising-edge clock, async active-high reset
//   io_flush             : squash any operation in flight
//   io_in_*              : valid/ready operand request (src1, src2, sign1, sign2)
//   io_out_*             : valid/ready full 2*XLEN-bit two's-complement product
// Operands are widened to XLEN+2 signed bits so every mode becomes a signed
// multiply; NITER digits then cover the widened multiplier exactly.
module booth_mul_iter
  import mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                io_flush,
  input  logic                io_in_valid,
  output logic                io_in_ready,
  input  logic [XLEN-1:0]     io_in_bits_src1,
  input  logic [XLEN-1:0]     io_in_bits_src2,
  input  logic                io_in_bits_sign1,
  input  logic                io_in_bits_sign2,
  output logic                io_out_valid,
  input  logic                io_out_ready,
  output logic [2*XLEN-1:0]   io_out_bits_result
);

  localparam int NITER = (XLEN+2)/2;
  localparam int AW    = 2*XLEN+4;
  localparam int YW    = XLEN+3;
  localparam int CW    = $clog2(NITER+1);

  state_e          r_state, w_state_nxt;
  logic [AW-1:0]   r_acc, r_xs;
  logic [YW-1:0]   r_y;
  logic [CW-1:0]   r_cnt;
  logic [2*XLEN-1:0] r_result;

  logic            w_accept, w_last, w_x_msb, w_y_msb;
  logic [AW-1:0]   w_addend, w_acc_nxt;

  assign w_accept  = (r_state == IDLE) && io_in_valid && !io_flush;
  assign w_last    = (r_cnt == CW'(NITER-1));
  assign w_x_msb   = io_in_bits_sign1 & io_in_bits_src1[XLEN-1];
  assign w_y_msb   = io_in_bits_sign2 & io_in_bits_src2[XLEN-1];
  assign w_acc_nxt = r_acc + w_addend;

  booth_pp_gen #(.XLEN(XLEN)) u_pp (
    .i_window (r_y[2:0]),
    .i_xs     (r_xs),
    .o_addend (w_addend)
  );

  always_comb begin
    w_state_nxt  = r_state;
    io_in_ready  = (r_state == IDLE);
    io_out_valid = (r_state == DONE);
    case (r_state)
      IDLE:    if (w_accept)     w_state_nxt = BUSY;
      BUSY:    if (w_last)       w_state_nxt = DONE;
      DONE:    if (io_out_ready) w_state_nxt = IDLE;
      default:                   w_state_nxt = IDLE;
    endcase
    // Flush overrides every transition, including a DONE handshake.
    if (io_flush) w_state_nxt = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_xs     <= '0;
      r_y      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_xs  <= {{(XLEN+4){w_x_msb}}, io_in_bits_src1};
      r_y   <= {{2{w_y_msb}}, io_in_bits_src2, 1'b0};
      r_cnt <= '0;
    end else if (r_state == BUSY && !io_flush) begin
      r_acc <= w_acc_nxt;
      r_xs  <= {r_xs[AW-3:0], 2'b00};
      r_y   <= {{2{r_y[YW-1]}}, r_y[YW-1:2]};
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_result <= w_acc_nxt[2*XLEN-1:0];
    end
  end

  assign io_out_bits_result = r_result;

endmodule

// File: tb/tb_booth_mul_iter.sv
module tb_booth_mul_iter;

  localparam int XLEN = 64;
  localparam int LAT  = (XLEN+2)/2 + 1;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              io_flush = 1'b0;
  logic              io_in_valid = 1'b0;
  logic              io_in_ready;
  logic [XLEN-1:0]   src1 = '0, src2 = '0;
  logic              sign1 = 1'b0, sign2 = 1'b0;
  logic              io_out_valid;
  logic              io_out_ready = 1'b1;
  logic [2*XLEN-1:0] io_out_bits_result;

  int n_chk = 0;
  int n_fail = 0;

  booth_mul_iter #(.XLEN(XLEN)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_flush           (io_flush),
    .io_in_valid        (io_in_valid),
    .io_in_ready        (io_in_ready),
    .io_in_bits_src1    (src1),
    .io_in_bits_src2    (src2),
    .io_in_bits_sign1   (sign1),
    .io_in_bits_sign2   (sign2),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_bits_result (io_out_bits_result)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: extend both operands to 128 bits per their sign mode; the
  // product modulo 2^128 is the full two's-complement result.
  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                           input logic sa, input logic sb);
    logic [127:0] ea, eb;
    ea = sa ? {{64{a[63]}}, a} : {64'b0, a};
    eb = sb ? {{64{b[63]}}, b} : {64'b0, b};
    return ea * eb;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issue one request; lat counts cycles from the accept cycle to io_out_valid.
  task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic sa,
                        input logic sb, output logic [127:0] r, output int lat);
    src1 = a; src2 = b; sign1 = sa; sign2 = sb;
    io_in_valid = 1'b1;
    step();
    io_in_valid = 1'b0;
    // Operands must be ignored once accepted.
    src1 = {$urandom, $urandom};
    src2 = {$urandom, $urandom};
    sign1 = 1'($urandom); sign2 = 1'($urandom);
    lat = 1;
    while (!io_out_valid && lat < 200) begin
      step();
      lat++;
    end
    r = io_out_bits_result;
    if (io_out_ready) step();
  endtask

  logic [127:0] r, held;
  logic [63:0]  a, b;
  int           lat;
  logic         seen;

  initial begin
    #12;
    chk("rst_out_valid", 128'(io_out_valid), 128'd0);
    chk("rst_in_ready", 128'(io_in_ready), 128'd1);
    chk("rst_result", io_out_bits_result, 128'd0);
    #2 reset = 1'b0;
    step();

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, r, lat);
    chk("umax", r, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    chk("umax_lat", 128'(lat), 128'(LAT));

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, r, lat);
    chk("smax", r, 128'd1);

    run_op(64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 1'b1, 1'b0, r, lat);
    chk("mixed", r, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA);

    // Backpressure: hold ready low in cycles 34..38, raise in 39.
    io_out_ready = 1'b0;
    run_op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1, r, lat);
    chk("bp_lat", 128'(lat), 128'(LAT));
    held = r;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 128'(io_out_valid), 128'd1);
      chk("bp_in_ready", 128'(io_in_ready), 128'd0);
      chk("bp_stable", io_out_bits_result, held);
      step();
    end
    chk("bp_result", held, ref_mul(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1));
    io_out_ready = 1'b1;
    chk("bp_valid39", 128'(io_out_valid), 128'd1);
    step();
    chk("bp_idle40", 128'(io_in_ready), 128'd1);
    chk("bp_novalid40", 128'(io_out_valid), 128'd0);

    // Flush beats a same-cycle request.
    src1 = 64'd5; src2 = 64'd5; io_in_valid = 1'b1; io_flush = 1'b1;
    step();
    io_in_valid = 1'b0; io_flush = 1'b0;
    chk("flush_beats_req", 128'(io_in_ready), 128'd1);

    // Flush in cycle 10 of an operation.
    src1 = 64'd99; src2 = 64'd77; sign1 = 1'b0; sign2 = 1'b0; io_in_valid = 1'b1;
    step();
    io_in_valid = 1'b0;
    repeat (9) step();
    io_flush = 1'b1;
    step();
    io_flush = 1'b0;
    chk("flush_idle", 128'(io_in_ready), 128'd1);
    chk("flush_novalid", 128'(io_out_valid), 128'd0);
    seen = 1'b0;
    repeat (40) begin
      step();
      if (io_out_valid) seen = 1'b1;
    end
    chk("flush_no_pulse", 128'(seen), 128'd0);
    run_op(64'd7, 64'd6, 1'b0, 1'b0, r, lat);
    chk("after_flush", r, 128'd42);

    // Flush in DONE coinciding with io_out_ready.
    io_out_ready = 1'b0;
    run_op(64'd3, 64'd4, 1'b0, 1'b0, r, lat);
    chk("done_flush_res", r, 128'd12);
    io_flush = 1'b1; io_out_ready = 1'b1;
    step();
    io_flush = 1'b0;
    chk("done_flush_idle", 128'(io_in_ready), 128'd1);
    chk("done_flush_novalid", 128'(io_out_valid), 128'd0);

    // Async reset between edges, mid-BUSY.
    src1 = 64'd1000; src2 = 64'd1000; io_in_valid = 1'b1;
    step();
    io_in_valid = 1'b0;
    repeat (5) step();
    #2 reset = 1'b1;
    #1;
    chk("arst_in_ready", 128'(io_in_ready), 128'd1);
    chk("arst_novalid", 128'(io_out_valid), 128'd0);
    chk("arst_result", io_out_bits_result, 128'd0);
    #1 reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      step();
      if (io_out_valid) seen = 1'b1;
    end
    chk("arst_no_output", 128'(seen), 128'd0);

    // Random regression across all four sign modes.
    for (int i = 0; i < 1000; i++) begin
      logic [1:0] mode;
      mode = 2'(i % 4);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 11))
        0: a = 64'h8000_0000_0000_0000;
        1: b = 64'h8000_0000_0000_0000;
        2: a = '1;
        3: b = '0;
        4: b = 64'h7FFF_FFFF_FFFF_FFFF;
        default: ;
      endcase
      run_op(a, b, mode[0], mode[1], r, lat);
      chk("rand", r, ref_mul(a, b, mode[0], mode[1]));
      chk("rand_lat", 128'(lat), 128'(LAT));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mul_iter.md
Name: booth_mul_iter

Overview:
- Iterative radix-4 Booth multiplier for the NPC execute stage.
- Parametrised in operand width; supports the signed×signed, signed×unsigned and unsigned×unsigned modes used by MUL/MULH/MULHSU/MULHU.
- Retires one Booth digit per cycle, so the combinational Wallace-tree multiplier can be dropped where area matters.
- Valid/ready on input and output; flush input for pipeline squash.

Parameters:
- XLEN, 64, operand width; must be even and >= 4.
- NITER, (XLEN+2)/2, Booth iteration count; derived, not overridable.

Ports:
- clock  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- io_flush  input  1  abort any operation in flight
- io_in_valid  input  1  operand request valid
- io_in_ready  output  1  block can accept a request
- io_in_bits_src1  input  XLEN  multiplicand
- io_in_bits_src2  input  XLEN  multiplier
- io_in_bits_sign1  input  1  1 = src1 is signed
- io_in_bits_sign2  input  1  1 = src2 is signed
- io_out_valid  output  1  result valid
- io_out_ready  input  1  consumer accepts result
- io_out_bits_result  output  2*XLEN  full product, two's complement

Behaviour:
- Interface: one clock, clock; reset is asynchronous and active-high, port reset.
- Reset values: state = IDLE, io_out_valid = 0, io_out_bits_result = 0, io_in_ready = 1.
- States:
  - IDLE: io_in_ready = 1. On io_in_valid & ~io_flush: latch operands, counter = 0, go to BUSY.
  - BUSY: io_in_ready = 0. Perform one iteration per cycle. After iteration NITER-1, go to DONE.
  - DONE: io_out_valid = 1 and the result is held stable. On io_out_ready, go to IDLE.
- Latch on accept:
  - X = src1 extended to XLEN+2 bits (sign-extend if sign1, else zero-extend).
  - Y = {src2 extended to XLEN+2 bits, 1'b0}.
  - acc = 0, of width 2*XLEN+4.
  - Xs = X sign-extended to 2*XLEN+4 bits.
- Iteration k:
  - Booth window w = Y[2:0], where w[2] = y_add, w[1] = y, w[0] = y_sub.
  - Selection:
    - 000 or 111: 0
    - 001 or 010: +Xs
    - 011: +2Xs
    - 100: -2Xs
    - 101 or 110: -Xs
  - Updates:
    - acc += selected value, modulo 2^(2*XLEN+4).
    - Xs <<= 2.
    - Y >>= 2, arithmetic shift.
    - counter += 1.
- Result: io_out_bits_result = acc[2*XLEN-1:0], registered on entry to DONE.
- Latency: request accepted in cycle 0 → io_out_valid high in cycle NITER+1 (cycle 34 for XLEN=64). Throughput is one operation per NITER+2 cycles with io_out_ready tied high.
- io_flush:
  - From any state, next state = IDLE and io_out_valid drops next cycle.
  - Flush beats a same-cycle input handshake: the request is not accepted.
  - Flush in DONE coinciding with io_out_ready still goes to IDLE; the consumer treats that result as squashed.
- Backpressure: in DONE with io_out_ready low, all outputs hold; io_in_ready stays 0.
- Reset mid-operation: immediate return to the reset values; no output is produced.
- Counter width: $clog2(NITER+1). Operand inputs are ignored outside the IDLE accept cycle.

Decomposition:
- Shared package mul_pkg holds:
  - Booth select encoding as a 4-bit one-hot: bit0 neg, bit1 pos, bit2 dbl_neg, bit3 dbl_pos. This matches the existing Wallace selector ordering.
  - State enum IDLE/BUSY/DONE.
- One sub-module, booth_pp_gen (purely combinational):
  - Inputs: 3-bit window, Xs.
  - Output: the 2*XLEN+4-bit addend.
  - Shared with the Wallace path.
- Accumulator, shifters, counter and FSM live in booth_mul_iter.

Test Plan:
- Unsigned max: src1 = src2 = 0xFFFF_FFFF_FFFF_FFFF, sign1 = sign2 = 0 → result = 0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- Signed: src1 = src2 = 0xFFFF_FFFF_FFFF_FFFF, sign1 = sign2 = 1 → result = 0x0000_0000_0000_0000_0000_0000_0000_0001.
- Mixed sign: src1 = 0xFFFF_FFFF_FFFF_FFFE (sign1 = 1), src2 = 3 (sign2 = 0) → result = 0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA.
- Latency / backpressure:
  - Accept in cycle 0 → io_out_valid rises in cycle 34.
  - Hold io_out_ready = 0 for 5 cycles → result is stable and io_in_ready = 0 throughout.
  - Ready in cycle 39 → IDLE in cycle 40.
- Flush in cycle 10 of BUSY → IDLE in cycle 11 with no io_out_valid pulse. Then src1 = 7, src2 = 6 unsigned → result = 42.
- Async reset asserted mid-BUSY, between clock edges → io_out_valid = 0 and io_in_ready = 1 immediately. Then run a 1000-operation random regression in all four sign modes against a reference model.
